// File: rtl/stats_collect.sv
// stats_collect: per-channel saturating accumulators, scanned round-robin and flushed through one AXI-Stream register.
// Optional periodic flush: define STATS_COLLECT_UPDATE_TIMER_EN to set all flags every UPDATE_PERIOD cycles.
module stats_collect #(
    parameter int COUNT          = 8,
    parameter int INC_WIDTH      = 8,
    parameter int STAT_INC_WIDTH = 16,
    parameter int STAT_ID_WIDTH  = 8,
    parameter int ID_BASE        = 0,
    parameter int UPDATE_PERIOD  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COUNT*INC_WIDTH-1:0] stat_inc,
    input  logic [COUNT-1:0]           stat_valid,
    input  logic                       update,
    output logic [STAT_INC_WIDTH-1:0]  m_axis_stat_tdata,
    output logic [STAT_ID_WIDTH-1:0]   m_axis_stat_tid,
    output logic                       m_axis_stat_tvalid,
    input  logic                       m_axis_stat_tready
);
    localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    generate
        if (COUNT < 2 || COUNT > 256 || (COUNT & (COUNT - 1)) != 0) begin : g_bad_count
            $error("stats_collect: COUNT must be a power of two in 2..256");
        end
        if (INC_WIDTH >= STAT_INC_WIDTH) begin : g_bad_inc
            $error("stats_collect: INC_WIDTH must be smaller than STAT_INC_WIDTH");
        end
        if (UPDATE_PERIOD < 1) begin : g_bad_period
            $error("stats_collect: UPDATE_PERIOD must be at least 1");
        end
    endgenerate

    function automatic logic [STAT_INC_WIDTH-1:0] sat_add(
        input logic [STAT_INC_WIDTH-1:0] a,
        input logic [INC_WIDTH-1:0]      b
    );
        logic [STAT_INC_WIDTH:0] s;
        s = {1'b0, a} + (STAT_INC_WIDTH+1)'(b);
        return s[STAT_INC_WIDTH] ? '1 : s[STAT_INC_WIDTH-1:0];
    endfunction

    logic [INC_WIDTH-1:0]      inc [COUNT];
    logic [STAT_INC_WIDTH-1:0] acc [COUNT];
    logic [COUNT-1:0]          flag;
    logic [IDX_W-1:0]          scan_idx;

    logic                      stall_p0;
    logic [STAT_INC_WIDTH-1:0] acc_sel;
    logic                      flag_sel;
    logic                      emit_p0;
    logic                      drop_p0;
    logic                      set_all;
    logic [STAT_ID_WIDTH-1:0]  tid_next;

    logic [STAT_INC_WIDTH-1:0] tdata_p1;
    logic [STAT_ID_WIDTH-1:0]  tid_p1;
    logic                      vld_p1;

    always_comb begin
        for (int n = 0; n < COUNT; n++) begin
            inc[n] = stat_inc[n*INC_WIDTH +: INC_WIDTH];
        end
    end

`ifdef STATS_COLLECT_UPDATE_TIMER_EN
    localparam int TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    logic [TMR_W-1:0] timer;
    logic             timer_hit;

    assign timer_hit = (timer == TMR_W'(UPDATE_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (timer_hit) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    assign set_all = update | timer_hit;
`else
    assign set_all = update;
`endif

    // Stage p0: inspect the channel under the scan index
    assign stall_p0 = vld_p1 & ~m_axis_stat_tready;
    assign acc_sel  = acc[scan_idx];
    assign flag_sel = flag[scan_idx];
    assign emit_p0  = ~stall_p0 & ((flag_sel & (acc_sel != '0)) | acc_sel[STAT_INC_WIDTH-1]);
    assign drop_p0  = ~stall_p0 & flag_sel & (acc_sel == '0);
    assign tid_next = STAT_ID_WIDTH'(ID_BASE) + STAT_ID_WIDTH'(scan_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx <= '0;
        end else if (!stall_p0) begin
            scan_idx <= scan_idx + IDX_W'(1);
        end
    end

    // An emitted channel restarts from its same-cycle increment; a flush request arriving
    // in the same cycle re-arms the flag so the pass after this one catches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < COUNT; n++) begin
                acc[n] <= '0;
            end
            flag <= '0;
        end else begin
            for (int n = 0; n < COUNT; n++) begin
                if (emit_p0 && scan_idx == IDX_W'(n)) begin
                    acc[n] <= stat_valid[n] ? STAT_INC_WIDTH'(inc[n]) : '0;
                end else if (stat_valid[n]) begin
                    acc[n] <= sat_add(acc[n], inc[n]);
                end

                if ((emit_p0 || drop_p0) && scan_idx == IDX_W'(n)) begin
                    flag[n] <= set_all;
                end else begin
                    flag[n] <= flag[n] | set_all;
                end
            end
        end
    end

    // Stage p1: single output register, reloadable in its own accept cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            tdata_p1 <= '0;
            tid_p1   <= '0;
        end else if (emit_p0) begin
            vld_p1   <= 1'b1;
            tdata_p1 <= acc_sel;
            tid_p1   <= tid_next;
        end else if (m_axis_stat_tready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign m_axis_stat_tdata  = tdata_p1;
    assign m_axis_stat_tid    = tid_p1;
    assign m_axis_stat_tvalid = vld_p1;

endmodule
